// File: rtl/pipeline_ctrl_n_pkg.sv
// Shared definitions for the pipeline controller: exception codes, handler
// vector defaults, FSM encoding and the redirect-target decode.
package pipeline_ctrl_n_pkg;

    localparam logic [31:0] EXC_NONE    = 32'h00000000;
    localparam logic [31:0] EXC_INT     = 32'h00000001;
    localparam logic [31:0] EXC_SYSCALL = 32'h00000008;
    localparam logic [31:0] EXC_RI      = 32'h0000000A;
    localparam logic [31:0] EXC_OV      = 32'h0000000C;
    localparam logic [31:0] EXC_TRAP    = 32'h0000000D;
    localparam logic [31:0] EXC_ERET    = 32'h0000000E;

    localparam logic [31:0] INT_VEC_DEF = 32'h00000020;
    localparam logic [31:0] EXC_VEC_DEF = 32'h00000040;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Interrupts and ERET have dedicated targets; every other nonzero code
    // (syscall, reserved instruction, overflow, trap, unknown) is general.
    function automatic logic [31:0] decode_target(
        input logic [31:0] code,
        input logic [31:0] epc,
        input logic [31:0] int_vec,
        input logic [31:0] exc_vec
    );
        logic [31:0] target;
        case (code)
            EXC_INT:  target = int_vec;
            EXC_ERET: target = epc;
            default:  target = exc_vec;
        endcase
        return target;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_n_stall_vec_gen.sv
// Combinational priority encoder: freezes every stage from the highest
// requesting stage (at least MIN_STALL) down to the PC stage.
module stall_vec_gen #(
    parameter int NSTAGE    = 6,
    parameter int MIN_STALL = 2
) (
    input  logic [NSTAGE-1:0] stallreq,
    output logic [NSTAGE-1:0] stall_vec
);

    logic any_req;

    assign any_req = |stallreq;

    genvar gi;
    generate
        for (gi = 0; gi < NSTAGE; gi++) begin : g_bit
            // A stage freezes if it or any later stage requests, or if it lies
            // inside the minimum frozen window while any request is present.
            assign stall_vec[gi] = (|stallreq[NSTAGE-1:gi]) |
                                   ((gi <= MIN_STALL) & any_req);
        end
    endgenerate

endmodule

// File: rtl/pipeline_ctrl_n.sv
// Pipeline hazard/exception controller: zero-latency stall vector, multi-cycle
// flush with PC redirect, stall watchdog and saturating stall counter.
module pipeline_ctrl_n
    import pipeline_ctrl_n_pkg::*;
#(
    parameter int          NSTAGE    = 6,
    parameter int          MIN_STALL = 2,
    parameter int          FLUSH_CYC = 1,
    parameter logic [31:0] INT_VEC   = INT_VEC_DEF,
    parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF,
    parameter int          WDOG_MAX  = 255,
    parameter int          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stallreq_i,
    input  logic [31:0]       excepttype_i,
    input  logic [31:0]       cp0_epc_i,
    input  logic              timeout_clr_i,
    output logic [NSTAGE-1:0] stall_o,
    output logic              flush_o,
    output logic [31:0]       new_pc_o,
    output logic              stall_timeout_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam int RUN_W = $clog2(WDOG_MAX + 1);
    localparam logic [RUN_W-1:0] WDOG_LIM = RUN_W'(WDOG_MAX);

    state_t            state_reg, state_next;
    logic [3:0]        fcnt_reg, fcnt_next;
    logic [31:0]       pc_reg, pc_next;
    logic [RUN_W-1:0]  run_reg, run_next;
    logic              timeout_reg, timeout_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;

    logic [NSTAGE-1:0] stall_vec;
    logic [NSTAGE-1:0] stall_int;
    logic              flush_int;
    logic [31:0]       new_pc_int;
    logic [31:0]       target;
    logic              stalled;
    logic              new_timeout;

    stall_vec_gen #(
        .NSTAGE   (NSTAGE),
        .MIN_STALL(MIN_STALL)
    ) u_stall_vec_gen (
        .stallreq (stallreq_i),
        .stall_vec(stall_vec)
    );

    assign target = decode_target(excepttype_i, cp0_epc_i, INT_VEC, EXC_VEC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            fcnt_reg    <= '0;
            pc_reg      <= '0;
            run_reg     <= '0;
            timeout_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            fcnt_reg    <= fcnt_next;
            pc_reg      <= pc_next;
            run_reg     <= run_next;
            timeout_reg <= timeout_next;
            cnt_reg     <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        fcnt_next  = fcnt_reg;
        pc_next    = pc_reg;
        stall_int  = '0;
        flush_int  = 1'b0;
        new_pc_int = '0;
        case (state_reg)
            ST_IDLE: begin
                if (excepttype_i != EXC_NONE) begin
                    flush_int  = 1'b1;
                    new_pc_int = target;
                    pc_next    = target;
                    if (FLUSH_CYC > 1) begin
                        state_next = ST_FLUSH;
                        fcnt_next  = 4'(FLUSH_CYC - 1);
                    end
                end else begin
                    stall_int = stall_vec;
                end
            end
            ST_FLUSH: begin
                // fcnt_reg holds the flush cycles still owed, this one included.
                flush_int  = 1'b1;
                new_pc_int = pc_reg;
                fcnt_next  = fcnt_reg - 4'd1;
                if (fcnt_reg <= 4'd1) begin
                    state_next = ST_IDLE;
                    fcnt_next  = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                fcnt_next  = '0;
            end
        endcase
    end

    assign stalled     = |stall_int;
    assign new_timeout = stalled && (run_reg >= (WDOG_LIM - 1'b1));

    always_comb begin
        run_next     = run_reg;
        timeout_next = timeout_reg;
        cnt_next     = cnt_reg;

        if (flush_int || !stalled) begin
            run_next = '0;
        end else if (run_reg != WDOG_LIM) begin
            run_next = run_reg + 1'b1;
        end

        // A clear that lands on a fresh timeout wins and restarts the run.
        if (timeout_clr_i) begin
            timeout_next = 1'b0;
            if (new_timeout) begin
                run_next = '0;
            end
        end else if (new_timeout) begin
            timeout_next = 1'b1;
        end

        if (stalled && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    assign stall_o         = rst ? '0 : stall_int;
    assign flush_o         = rst ? 1'b0 : flush_int;
    assign new_pc_o        = rst ? '0 : new_pc_int;
    assign stall_timeout_o = timeout_reg;
    assign stall_cnt_o     = cnt_reg;

endmodule

// File: tb/tb_pipeline_ctrl_n.sv
// Directed bench for pipeline_ctrl_n with FLUSH_CYC=3, WDOG_MAX=4, CNT_W=3;
// inputs change 1 ns after the rising edge and outputs are sampled 1 ns later.
module tb_pipeline_ctrl_n;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stallreq_i;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic        timeout_clr_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        stall_timeout_o;
    logic [2:0]  stall_cnt_o;

    int errors = 0;
    int checks = 0;

    pipeline_ctrl_n #(
        .NSTAGE   (6),
        .MIN_STALL(2),
        .FLUSH_CYC(3),
        .INT_VEC  (32'h00000020),
        .EXC_VEC  (32'h00000040),
        .WDOG_MAX (4),
        .CNT_W    (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_i     (stallreq_i),
        .excepttype_i   (excepttype_i),
        .cp0_epc_i      (cp0_epc_i),
        .timeout_clr_i  (timeout_clr_i),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .new_pc_o       (new_pc_o),
        .stall_timeout_o(stall_timeout_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            $display("check %-14s obs=%h exp=%h ok", tag, obs, exp);
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst           = 1'b1;
        stallreq_i    = 6'b001000;
        excepttype_i  = 32'h0;
        cp0_epc_i     = 32'h0;
        timeout_clr_i = 1'b0;
        #2;
        check("rst_stall", 32'(stall_o), 32'h0);
        check("rst_flush", 32'(flush_o), 32'h0);
        check("rst_cnt", 32'(stall_cnt_o), 32'h0);
        check("rst_tmo", 32'(stall_timeout_o), 32'h0);
        stallreq_i = 6'b0;
        tick();
        rst = 1'b0;
        #1;
        check("idle_stall", 32'(stall_o), 32'h0);

        // Zero-latency thermometer stall vector
        stallreq_i = 6'b001000; #1;
        check("stall_h3", 32'(stall_o), 32'h0f);
        check("cnt_0", 32'(stall_cnt_o), 32'h0);
        tick();
        stallreq_i = 6'b000010; #1;
        check("stall_h1", 32'(stall_o), 32'h07);
        tick();
        stallreq_i = 6'b100001; #1;
        check("stall_h5", 32'(stall_o), 32'h3f);
        stallreq_i = 6'b000000; #1;
        check("stall_none", 32'(stall_o), 32'h0);
        check("cnt_2", 32'(stall_cnt_o), 32'h2);
        tick();

        // ERET beats a stall request; flush lasts 3 cycles, stalls ignored
        excepttype_i = 32'h0E; cp0_epc_i = 32'h1234; stallreq_i = 6'b010000; #1;
        check("eret_flush", 32'(flush_o), 32'h1);
        check("eret_pc", new_pc_o, 32'h1234);
        check("eret_stall", 32'(stall_o), 32'h0);
        tick();
        excepttype_i = 32'h0; cp0_epc_i = 32'h0; #1;
        check("eret_c2_flush", 32'(flush_o), 32'h1);
        check("eret_c2_pc", new_pc_o, 32'h1234);
        check("eret_c2_stall", 32'(stall_o), 32'h0);
        tick();
        check("eret_c3_flush", 32'(flush_o), 32'h1);
        stallreq_i = 6'b0;
        tick();
        check("eret_end_fl", 32'(flush_o), 32'h0);
        check("eret_end_pc", new_pc_o, 32'h0);
        check("cnt_still_2", 32'(stall_cnt_o), 32'h2);

        // Interrupt: exactly 3 flush cycles, second exception ignored
        excepttype_i = 32'h01; #1;
        check("int_c1_flush", 32'(flush_o), 32'h1);
        check("int_c1_pc", new_pc_o, 32'h20);
        tick();
        excepttype_i = 32'h0C; #1;
        check("int_c2_flush", 32'(flush_o), 32'h1);
        check("int_c2_pc", new_pc_o, 32'h20);
        tick();
        excepttype_i = 32'h0; #1;
        check("int_c3_flush", 32'(flush_o), 32'h1);
        check("int_c3_pc", new_pc_o, 32'h20);
        tick();
        check("int_c4_flush", 32'(flush_o), 32'h0);

        // General exception vectors
        excepttype_i = 32'h08; #1;
        check("sys_pc", new_pc_o, 32'h40);
        tick();
        excepttype_i = 32'h0;
        tick();
        tick();
        check("sys_end_fl", 32'(flush_o), 32'h0);
        excepttype_i = 32'h33; #1;
        check("unk_pc", new_pc_o, 32'h40);
        tick();
        excepttype_i = 32'h0;
        tick();
        tick();

        // Watchdog: timeout after the 4th consecutive stalled cycle
        stallreq_i = 6'b000100;
        tick(); tick(); tick();
        check("wd_3_tmo", 32'(stall_timeout_o), 32'h0);
        tick();
        check("wd_4_tmo", 32'(stall_timeout_o), 32'h1);
        check("cnt_6", 32'(stall_cnt_o), 32'h6);
        tick();
        check("wd_5_tmo", 32'(stall_timeout_o), 32'h1);
        check("cnt_7", 32'(stall_cnt_o), 32'h7);
        stallreq_i = 6'b0;
        tick();
        check("wd_sticky", 32'(stall_timeout_o), 32'h1);
        timeout_clr_i = 1'b1;
        tick();
        timeout_clr_i = 1'b0; #1;
        check("wd_clr", 32'(stall_timeout_o), 32'h0);

        // Counter saturates; clear coinciding with a new timeout restarts run
        stallreq_i = 6'b000001;
        tick(); tick(); tick();
        check("cnt_sat", 32'(stall_cnt_o), 32'h7);
        timeout_clr_i = 1'b1;
        tick();
        timeout_clr_i = 1'b0; #1;
        check("wd_coinc", 32'(stall_timeout_o), 32'h0);
        tick(); tick(); tick();
        check("wd_rst_run3", 32'(stall_timeout_o), 32'h0);
        tick();
        check("wd_rst_run4", 32'(stall_timeout_o), 32'h1);
        stallreq_i = 6'b0;
        tick();

        // Reset during a flush aborts it immediately
        excepttype_i = 32'h01;
        tick();
        excepttype_i = 32'h0; #1;
        check("pre_rst_flush", 32'(flush_o), 32'h1);
        rst = 1'b1; #1;
        check("mid_rst_flush", 32'(flush_o), 32'h0);
        check("mid_rst_pc", new_pc_o, 32'h0);
        check("mid_rst_tmo", 32'(stall_timeout_o), 32'h0);
        check("mid_rst_cnt", 32'(stall_cnt_o), 32'h0);
        tick();
        rst = 1'b0; #1;
        check("post_rst_st", 32'(stall_o), 32'h0);
        check("post_rst_fl", 32'(flush_o), 32'h0);
        excepttype_i = 32'h0E; cp0_epc_i = 32'h55; #1;
        check("post_rst_pc", new_pc_o, 32'h55);
        tick();
        excepttype_i = 32'h0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
